// File: rtl/mult_accum.sv
// Sequential multiply-accumulate: sums N_TERMS 4-bit products per result over
// valid/ready handshakes on both sides, with a sticky carry-out flag.
module mult_accum #(
    parameter int unsigned N_TERMS = 4,
    parameter int unsigned ACC_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       prod,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             overflow,
    output logic [7:0]       term_cnt
);

    localparam int unsigned SUM_W = ACC_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [ACC_W-1:0]   acc_n;
    logic               overflow_n;
    logic [7:0]         term_cnt_n;
    logic               out_valid_n;
    logic [SUM_W-1:0]   sum_c;
    logic               accept_c;

    // Ready is a decode of the registered state so it never depends on in_valid
    assign in_ready = (state != DONE);
    assign accept_c = in_valid && in_ready;
    assign sum_c    = {1'b0, acc_out} + SUM_W'(prod);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc_out   <= '0;
            overflow  <= 1'b0;
            term_cnt  <= 8'd0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_n;
            acc_out   <= acc_n;
            overflow  <= overflow_n;
            term_cnt  <= term_cnt_n;
            out_valid <= out_valid_n;
        end
    end

    always_comb begin
        state_n    = state;
        acc_n      = acc_out;
        overflow_n = overflow;
        term_cnt_n = term_cnt;

        if (clear) begin
            state_n    = IDLE;
            acc_n      = '0;
            overflow_n = 1'b0;
            term_cnt_n = 8'd0;
        end else begin
            case (state)
                IDLE, ACC: begin
                    if (accept_c) begin
                        acc_n      = sum_c[ACC_W-1:0];
                        overflow_n = overflow | sum_c[ACC_W];
                        term_cnt_n = term_cnt + 8'd1;
                        state_n    = (term_cnt_n == 8'(N_TERMS)) ? DONE : ACC;
                    end
                end
                DONE: begin
                    // Result consumed: drop back for the next dot product
                    if (out_ready) begin
                        state_n    = IDLE;
                        acc_n      = '0;
                        overflow_n = 1'b0;
                        term_cnt_n = 8'd0;
                    end
                end
                default: begin
                    state_n    = IDLE;
                    acc_n      = '0;
                    overflow_n = 1'b0;
                    term_cnt_n = 8'd0;
                end
            endcase
        end

        out_valid_n = (state_n == DONE);
    end

endmodule

// File: tb/tb_mult_accum.sv
// Directed bench for mult_accum: default, narrow-accumulator and single-term
// instances driven from one linear stimulus sequence.
module tb_mult_accum;

    logic clk = 1'b0;
    logic rst;
    logic clear;

    // u0: N_TERMS=4, ACC_W=8
    logic       v0, r0, rdy0, ov0, of0;
    logic [3:0] p0;
    logic [7:0] acc0, cnt0;
    // u1: N_TERMS=4, ACC_W=5
    logic       v1, r1, rdy1, ov1, of1;
    logic [3:0] p1;
    logic [4:0] acc1;
    logic [7:0] cnt1;
    // u2: N_TERMS=1, ACC_W=8
    logic       v2, r2, rdy2, ov2, of2;
    logic [3:0] p2;
    logic [7:0] acc2, cnt2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mult_accum u0 (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(v0), .in_ready(rdy0), .prod(p0),
        .out_valid(ov0), .out_ready(r0),
        .acc_out(acc0), .overflow(of0), .term_cnt(cnt0)
    );

    mult_accum #(.N_TERMS(4), .ACC_W(5)) u1 (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(v1), .in_ready(rdy1), .prod(p1),
        .out_valid(ov1), .out_ready(r1),
        .acc_out(acc1), .overflow(of1), .term_cnt(cnt1)
    );

    mult_accum #(.N_TERMS(1), .ACC_W(8)) u2 (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(v2), .in_ready(rdy2), .prod(p2),
        .out_valid(ov2), .out_ready(r2),
        .acc_out(acc2), .overflow(of2), .term_cnt(cnt2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Full output snapshot of u0
    task automatic chk0(input string tag, input logic [7:0] acc, input logic [7:0] cnt,
                        input logic ov, input logic rdy, input logic of);
        check({tag, ".acc"},   32'(acc0), 32'(acc));
        check({tag, ".cnt"},   32'(cnt0), 32'(cnt));
        check({tag, ".valid"}, 32'(ov0),  32'(ov));
        check({tag, ".ready"}, 32'(rdy0), 32'(rdy));
        check({tag, ".ovf"},   32'(of0),  32'(of));
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0;
        v0 = 0; p0 = 0; r0 = 1;
        v1 = 0; p1 = 0; r1 = 1;
        v2 = 0; p2 = 0; r2 = 1;
        #12;
        chk0("reset", 8'd0, 8'd0, 1'b0, 1'b1, 1'b0);
        check("reset.u1acc", 32'(acc1), 32'd0);
        check("reset.u2valid", 32'(ov2), 32'd0);
        tick;
        rst = 1'b0;

        // Basic sum 9+6+4+1 = 20, back-to-back
        v0 = 1; p0 = 4'd9; tick; chk0("basic1", 8'd9,  8'd1, 1'b0, 1'b1, 1'b0);
        p0 = 4'd6;         tick; chk0("basic2", 8'd15, 8'd2, 1'b0, 1'b1, 1'b0);
        p0 = 4'd4;         tick; chk0("basic3", 8'd19, 8'd3, 1'b0, 1'b1, 1'b0);
        p0 = 4'd1;         tick; chk0("basic_done", 8'd20, 8'd4, 1'b1, 1'b0, 1'b0);
        v0 = 0;            tick; chk0("basic_idle", 8'd0, 8'd0, 1'b0, 1'b1, 1'b0);

        // Backpressure: result held, prod offered during DONE is ignored
        r0 = 0;
        v0 = 1; p0 = 4'd9; tick;
        p0 = 4'd6; tick;
        p0 = 4'd4; tick;
        p0 = 4'd1; tick; chk0("bp_done", 8'd20, 8'd4, 1'b1, 1'b0, 1'b0);
        p0 = 4'd9;
        for (int i = 0; i < 5; i++) begin
            tick; chk0("bp_hold", 8'd20, 8'd4, 1'b1, 1'b0, 1'b0);
        end
        r0 = 1; tick; chk0("bp_release", 8'd0, 8'd0, 1'b0, 1'b1, 1'b0);
        tick; chk0("bp_next", 8'd9, 8'd1, 1'b0, 1'b1, 1'b0);
        v0 = 0;

        // Clear mid-ACC has priority over an offered product
        clear = 1; tick; clear = 0;
        chk0("clr_pre", 8'd0, 8'd0, 1'b0, 1'b1, 1'b0);
        v0 = 1; p0 = 4'd5; tick; p0 = 4'd5; tick;
        chk0("clr_55", 8'd10, 8'd2, 1'b0, 1'b1, 1'b0);
        clear = 1; p0 = 4'd7; tick; clear = 0;
        chk0("clr_idle", 8'd0, 8'd0, 1'b0, 1'b1, 1'b0);
        p0 = 4'd1; tick; tick; tick; tick;
        chk0("clr_1111", 8'd4, 8'd4, 1'b1, 1'b0, 1'b0);
        v0 = 0; tick;

        // Clear in DONE with out_ready high still aborts to IDLE
        v0 = 1; p0 = 4'd2; r0 = 0; tick; tick; tick; tick;
        chk0("clrd_done", 8'd8, 8'd4, 1'b1, 1'b0, 1'b0);
        v0 = 0; r0 = 1; clear = 1; tick; clear = 0;
        chk0("clrd_idle", 8'd0, 8'd0, 1'b0, 1'b1, 1'b0);

        // Input gaps: 3, gap x3, 3, gap, 3, 3
        v0 = 1; p0 = 4'd3; tick; chk0("gap1", 8'd3, 8'd1, 1'b0, 1'b1, 1'b0);
        v0 = 0;
        for (int i = 0; i < 3; i++) begin
            tick; chk0("gap_hold", 8'd3, 8'd1, 1'b0, 1'b1, 1'b0);
        end
        v0 = 1; tick; chk0("gap2", 8'd6, 8'd2, 1'b0, 1'b1, 1'b0);
        v0 = 0; tick; chk0("gap_hold2", 8'd6, 8'd2, 1'b0, 1'b1, 1'b0);
        v0 = 1; tick; chk0("gap3", 8'd9, 8'd3, 1'b0, 1'b1, 1'b0);
        tick; chk0("gap_done", 8'd12, 8'd4, 1'b1, 1'b0, 1'b0);
        v0 = 0; tick; chk0("gap_idle", 8'd0, 8'd0, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset mid-ACC, observed before the next edge
        v0 = 1; p0 = 4'd2; tick; tick; v0 = 0;
        chk0("ar_pre", 8'd4, 8'd2, 1'b0, 1'b1, 1'b0);
        #2; rst = 1; #1;
        chk0("ar_async", 8'd0, 8'd0, 1'b0, 1'b1, 1'b0);
        #1; rst = 0;
        tick;

        // Overflow with ACC_W=5: 27+9 = 36 -> 4 with carry
        v1 = 1; p1 = 4'd9; tick; tick; tick;
        check("ovf3.acc", 32'(acc1), 32'd27);
        check("ovf3.ovf", 32'(of1),  32'd0);
        tick;
        check("ovf4.acc",   32'(acc1), 32'd4);
        check("ovf4.ovf",   32'(of1),  32'd1);
        check("ovf4.valid", 32'(ov1),  32'd1);
        check("ovf4.cnt",   32'(cnt1), 32'd4);
        v1 = 0; tick;
        check("ovf_clr.ovf",   32'(of1),  32'd0);
        check("ovf_clr.acc",   32'(acc1), 32'd0);
        check("ovf_clr.valid", 32'(ov1),  32'd0);

        // N_TERMS=1: alternating accept / DONE under continuous traffic
        v2 = 1; p2 = 4'd7;
        for (int i = 0; i < 2; i++) begin
            tick;
            check("n1_done.acc",   32'(acc2), 32'd7);
            check("n1_done.valid", 32'(ov2),  32'd1);
            check("n1_done.ready", 32'(rdy2), 32'd0);
            check("n1_done.cnt",   32'(cnt2), 32'd1);
            tick;
            check("n1_idle.acc",   32'(acc2), 32'd0);
            check("n1_idle.valid", 32'(ov2),  32'd0);
            check("n1_idle.ready", 32'(rdy2), 32'd1);
        end
        v2 = 0;
        tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
